// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: interrupt entry (drain, push PC, vector) and RTI return (pop PC, restore CCR)
module interrupt_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] VECTOR_ADDR  = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_interrupt,
  input  logic        i_rti_decoded,
  input  logic        i_branch_taken,
  input  logic [31:0] i_pc_current,
  input  logic [3:0]  i_ccr,
  input  logic        i_mem_ready,
  input  logic [15:0] i_mem_rdata,
  output logic        o_stall_fetch,
  output logic        o_inject_bubble,
  output logic        o_mem_req,
  output logic        o_mem_write,
  output logic [1:0]  o_sp_op,
  output logic [15:0] o_mem_wdata,
  output logic        o_pc_load,
  output logic [31:0] o_pc_load_value,
  output logic        o_flags_load,
  output logic [3:0]  o_flags_value,
  output logic        o_int_ack,
  output logic        o_busy
);
  typedef enum logic [3:0] {
    S_IDLE, S_DRAIN, S_PUSH_HI, S_PUSH_LO, S_REDIR,
    S_R_DRAIN, S_POP_LO, S_POP_HI, S_R_REDIR
  } state_t;
  localparam logic [3:0] LP_LAST = 4'(DRAIN_CYCLES - 1);
  state_t      r_state, w_next;
  logic        r_int_prev, r_int_pend;
  logic [3:0]  r_cnt;
  logic [31:0] r_saved_pc, r_ret_pc;
  logic [3:0]  r_saved_ccr;
  logic        w_int_edge, w_take_int, w_drain_done;
  assign w_int_edge   = i_interrupt & ~r_int_prev;
  assign w_take_int   = (r_state == S_IDLE) & r_int_pend & ~i_branch_taken;
  assign w_drain_done = (r_cnt == LP_LAST);
  // state register
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  // the request is consumed when entry starts, so an edge arriving anywhere
  // in the sequence (even during the push) is kept for a later entry
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_int_prev <= 1'b0;
      r_int_pend <= 1'b0;
    end else begin
      r_int_prev <= i_interrupt;
      r_int_pend <= w_int_edge | (r_int_pend & ~w_take_int);
    end
  // drain counter, saved resume PC/CCR and popped return PC
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_cnt       <= 4'd0;
      r_saved_pc  <= 32'd0;
      r_ret_pc    <= 32'd0;
      r_saved_ccr <= 4'd0;
    end else begin
      r_cnt <= (r_state == S_DRAIN || r_state == S_R_DRAIN) ? r_cnt + 4'd1 : 4'd0;
      if (w_take_int) r_saved_pc <= i_pc_current;
      if (r_state == S_DRAIN && w_drain_done) r_saved_ccr <= i_ccr;
      if (r_state == S_POP_LO && i_mem_ready) r_ret_pc[15:0] <= i_mem_rdata;
      if (r_state == S_POP_HI && i_mem_ready) r_ret_pc[31:16] <= i_mem_rdata;
    end
  // next state; interrupt outranks RTI, and a branch flush defers entry one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = w_take_int ? S_DRAIN : r_int_pend ? S_IDLE :
                          i_rti_decoded ? S_R_DRAIN : S_IDLE;
      S_DRAIN:   w_next = w_drain_done ? S_PUSH_HI : S_DRAIN;
      S_PUSH_HI: w_next = i_mem_ready ? S_PUSH_LO : S_PUSH_HI;
      S_PUSH_LO: w_next = i_mem_ready ? S_REDIR : S_PUSH_LO;
      S_R_DRAIN: w_next = w_drain_done ? S_POP_LO : S_R_DRAIN;
      S_POP_LO:  w_next = i_mem_ready ? S_POP_HI : S_POP_LO;
      S_POP_HI:  w_next = i_mem_ready ? S_R_REDIR : S_POP_HI;
      default:   w_next = S_IDLE;
    endcase
  end
  // Moore outputs decoded from state alone so they stay stable while memory stalls
  always_comb begin
    o_stall_fetch   = r_state != S_IDLE;
    o_inject_bubble = r_state != S_IDLE;
    o_busy          = r_state != S_IDLE;
    o_mem_req       = 1'b0;
    o_mem_write     = 1'b0;
    o_sp_op         = 2'b00;
    o_mem_wdata     = 16'd0;
    o_pc_load       = 1'b0;
    o_pc_load_value = 32'd0;
    o_flags_load    = 1'b0;
    o_flags_value   = 4'd0;
    o_int_ack       = 1'b0;
    case (r_state)
      S_PUSH_HI, S_PUSH_LO: begin
        o_mem_req   = 1'b1;
        o_mem_write = 1'b1;
        o_sp_op     = 2'b01;
        o_mem_wdata = (r_state == S_PUSH_HI) ? r_saved_pc[31:16] : r_saved_pc[15:0];
      end
      S_POP_LO, S_POP_HI: begin
        o_mem_req = 1'b1;
        o_sp_op   = 2'b10;
      end
      S_REDIR: begin
        o_pc_load       = 1'b1;
        o_pc_load_value = VECTOR_ADDR;
        o_int_ack       = 1'b1;
      end
      S_R_REDIR: begin
        o_pc_load       = 1'b1;
        o_pc_load_value = r_ret_pc;
        o_flags_load    = 1'b1;
        o_flags_value   = r_saved_ccr;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed checks of interrupt entry, RTI return, stalls, deferral and reset
module tb_interrupt_sequencer;
  localparam int unsigned D = 3;
  localparam logic [31:0] VEC = 32'h0000_0100;
  logic clk = 1'b0, rst = 1'b1;
  logic intr = 1'b0, rti = 1'b0, br = 1'b0, rdy = 1'b1;
  logic [31:0] pc = 32'd0;
  logic [3:0] ccr = 4'd0;
  logic [15:0] rdata = 16'd0;
  logic stall, bubble, mreq, mwr, pl, fl, ack, busy;
  logic [1:0] sp;
  logic [15:0] wd;
  logic [31:0] pv;
  logic [3:0] fv;
  logic [63:0] obs;
  int n_vec = 0, n_err = 0, pushes = 0;
  interrupt_sequencer #(.DRAIN_CYCLES(D), .VECTOR_ADDR(VEC)) dut (
    .i_clk(clk), .i_reset(rst), .i_interrupt(intr), .i_rti_decoded(rti),
    .i_branch_taken(br), .i_pc_current(pc), .i_ccr(ccr), .i_mem_ready(rdy),
    .i_mem_rdata(rdata), .o_stall_fetch(stall), .o_inject_bubble(bubble),
    .o_mem_req(mreq), .o_mem_write(mwr), .o_sp_op(sp), .o_mem_wdata(wd),
    .o_pc_load(pl), .o_pc_load_value(pv), .o_flags_load(fl), .o_flags_value(fv),
    .o_int_ack(ack), .o_busy(busy)
  );
  always #5 clk = ~clk;
  assign obs = {2'b00, stall, bubble, busy, mreq, mwr, sp, wd, pl, pv, fl, fv, ack};
  always @(posedge clk) if (!rst && mreq && mwr && rdy) pushes <= pushes + 1;
  function automatic logic [63:0] ex(input logic b, input logic rq, input logic wr,
      input logic [1:0] s, input logic [15:0] d, input logic l, input logic [31:0] v,
      input logic f, input logic [3:0] c, input logic a);
    return {2'b00, b, b, b, rq, wr, s, d, l, v, f, c, a};
  endfunction
  localparam logic [63:0] E_IDLE = 64'd0;
  function automatic logic [63:0] e_busy();  return ex(1,0,0,2'b00,16'd0,0,32'd0,0,4'd0,0); endfunction
  function automatic logic [63:0] e_push(input logic [15:0] d); return ex(1,1,1,2'b01,d,0,32'd0,0,4'd0,0); endfunction
  function automatic logic [63:0] e_pop();   return ex(1,1,0,2'b10,16'd0,0,32'd0,0,4'd0,0); endfunction
  function automatic logic [63:0] e_redir(); return ex(1,0,0,2'b00,16'd0,1,VEC,0,4'd0,1); endfunction
  function automatic logic [63:0] e_rredir(input logic [31:0] p, input logic [3:0] c);
    return ex(1,0,0,2'b00,16'd0,1,p,1,c,0);
  endfunction
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  task automatic drain(input string tag);
    repeat (D) begin chk(tag, obs, e_busy()); tick(); end
  endtask
  initial begin
    tick(); tick();
    chk("reset_outputs", obs, E_IDLE);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", obs, E_IDLE);
    // 1: basic entry
    pc = 32'h0001_2345; ccr = 4'h5; rdy = 1'b1;
    intr = 1'b1; tick();
    chk("t1_latch_idle", obs, E_IDLE);
    intr = 1'b0; tick();
    drain("t1_drain");
    chk("t1_push_hi", obs, e_push(16'h0001)); tick();
    chk("t1_push_lo", obs, e_push(16'h2345)); tick();
    chk("t1_redir", obs, e_redir()); tick();
    chk("t1_idle", obs, E_IDLE);
    chk("t1_push_count", 64'(pushes), 64'd2);
    // 3: RTI return restores PC and the CCR snapshot taken at entry
    ccr = 4'hF; rti = 1'b1; tick();
    rti = 1'b0;
    drain("t3_rdrain");
    rdata = 16'h2345;
    chk("t3_pop_lo", obs, e_pop()); tick();
    rdata = 16'h0001;
    chk("t3_pop_hi", obs, e_pop()); tick();
    chk("t3_rredir", obs, e_rredir(32'h0001_2345, 4'h5)); tick();
    chk("t3_idle", obs, E_IDLE);
    chk("t3_push_count", 64'(pushes), 64'd2);
    // 2: memory stall in PUSH_HI holds request and data
    pc = 32'hCAFE_BEEF; rdy = 1'b0;
    intr = 1'b1; tick();
    intr = 1'b0; tick();
    drain("t2_drain");
    repeat (4) begin chk("t2_hold", obs, e_push(16'hCAFE)); tick(); end
    chk("t2_push_hi", obs, e_push(16'hCAFE));
    rdy = 1'b1; tick();
    chk("t2_push_lo", obs, e_push(16'hBEEF)); tick();
    chk("t2_redir", obs, e_redir()); tick();
    chk("t2_idle", obs, E_IDLE);
    chk("t2_push_count", 64'(pushes), 64'd4);
    // 4: branch flush defers entry; branch target is saved
    pc = 32'h0000_0500;
    intr = 1'b1; tick();
    intr = 1'b0; br = 1'b1; tick();
    chk("t4_hold_idle", obs, E_IDLE);
    br = 1'b0; pc = 32'h0000_0040; tick();
    drain("t4_drain");
    chk("t4_push_hi", obs, e_push(16'h0000)); tick();
    chk("t4_push_lo", obs, e_push(16'h0040)); tick();
    chk("t4_redir", obs, e_redir()); tick();
    chk("t4_idle", obs, E_IDLE);
    // 5: edge during PUSH_LO causes a second entry after IDLE
    pc = 32'h1111_2222;
    intr = 1'b1; tick();
    intr = 1'b0; tick();
    drain("t5_drain");
    chk("t5_push_hi", obs, e_push(16'h1111)); tick();
    chk("t5_push_lo", obs, e_push(16'h2222));
    intr = 1'b1; tick();
    chk("t5_redir", obs, e_redir());
    intr = 1'b0; pc = 32'h3333_4444; tick();
    chk("t5_gap_idle", obs, E_IDLE); tick();
    drain("t5_drain2");
    chk("t5_push_hi2", obs, e_push(16'h3333)); tick();
    chk("t5_push_lo2", obs, e_push(16'h4444)); tick();
    chk("t5_redir2", obs, e_redir()); tick();
    repeat (3) begin chk("t5_stay_idle", obs, E_IDLE); tick(); end
    chk("t5_push_count", 64'(pushes), 64'd10);
    // 6: asynchronous reset in PUSH_HI
    pc = 32'h5555_6666; rdy = 1'b0;
    intr = 1'b1; tick();
    intr = 1'b0; tick();
    drain("t6_drain");
    chk("t6_push_hi", obs, e_push(16'h5555));
    rst = 1'b1; #1;
    chk("t6_async_reset", obs, E_IDLE);
    tick();
    chk("t6_in_reset", obs, E_IDLE);
    rst = 1'b0; rdy = 1'b1; tick();
    repeat (3) begin chk("t6_no_pend", obs, E_IDLE); tick(); end
    chk("t6_push_count", 64'(pushes), 64'd10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
